// File: rtl/mic_pkg.sv
// Shared definitions for the mic input path.
//   snr_evt_state_t : state encoding of the SNR voice-event detector
//   ON_DB_DEFAULT   : default signed dB level that starts an event
//   OFF_DB_DEFAULT  : default signed dB level that keeps an event alive
//   cnt_width()     : bits needed to hold a counter that reaches max_val
package mic_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        ACTIVE  = 3'd2,
        RELEASE = 3'd3,
        REPORT  = 3'd4
    } snr_evt_state_t;

    localparam int ON_DB_DEFAULT  = 12;
    localparam int OFF_DB_DEFAULT = 6;

    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and load.
// Priority: clr > load > inc. Increment stops at all-ones.
//   clk, reset  : clock, asynchronous active-high reset (count -> 0)
//   clr         : force count to 0
//   load        : load load_val
//   load_val    : value loaded when load is high
//   inc         : add one unless already saturated
//   count       : current value
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/snr_event_detector.sv
// Voice-event detector sitting after the SNR calculator.
// Debounces the start of an event (ATTACK_N samples >= ON_DB), applies
// hysteresis with a hold-off (HOLD_N samples < OFF_DB) at the end, and
// emits one record {peak snr, peak rms, length} per completed event.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. Input side: in_valid/in_ready (in_ready drops only while a
// record is pending). Output side: ev_valid/ev_ready; the record is held
// stable while ev_valid is high and ev_ready is low.
//
// Ports:
//   clk, reset     : clock, asynchronous active-high reset
//   quiet_period   : calibration running; discards any event in progress
//   snr_db         : signed SNR sample (integer dB)
//   signal_rms     : unsigned short-term RMS sample
//   in_valid       : sample valid
//   in_ready       : sample accepted when in_valid & in_ready
//   voice_active   : high while in ACTIVE or RELEASE
//   ev_peak_snr    : record, max snr_db over counted event samples
//   ev_peak_rms    : record, max signal_rms over counted event samples
//   ev_len         : record, samples from ACTIVE entry to last >= OFF_DB
//   ev_valid       : record valid
//   ev_ready       : record consumed when ev_valid & ev_ready
//   state_dbg      : current FSM state, for observation only
module snr_event_detector
    import mic_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int SNR_WIDTH  = 16,
    parameter int LEN_WIDTH  = 16,
    parameter int ON_DB      = ON_DB_DEFAULT,
    parameter int OFF_DB     = OFF_DB_DEFAULT,
    parameter int ATTACK_N   = 4,
    parameter int HOLD_N     = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         quiet_period,
    input  logic signed [SNR_WIDTH-1:0]  snr_db,
    input  logic        [DATA_WIDTH-1:0] signal_rms,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic                         voice_active,
    output logic signed [SNR_WIDTH-1:0]  ev_peak_snr,
    output logic        [DATA_WIDTH-1:0] ev_peak_rms,
    output logic        [LEN_WIDTH-1:0]  ev_len,
    output logic                         ev_valid,
    input  logic                         ev_ready,
    output snr_evt_state_t               state_dbg
);

    localparam int ATT_W  = cnt_width(ATTACK_N);
    localparam int HOLD_W = cnt_width(HOLD_N);
    localparam int SUM_W  = LEN_WIDTH + HOLD_W + 1;

    localparam logic signed [SNR_WIDTH-1:0] ON_TH  = SNR_WIDTH'(ON_DB);
    localparam logic signed [SNR_WIDTH-1:0] OFF_TH = SNR_WIDTH'(OFF_DB);
    localparam logic [ATT_W-1:0]     ATT_LAST  = ATT_W'(ATTACK_N - 1);
    localparam logic [HOLD_W-1:0]    HOLD_LAST = HOLD_W'(HOLD_N - 1);
    localparam logic [LEN_WIDTH-1:0] LEN_MAX   = '1;
    localparam logic [LEN_WIDTH-1:0] LEN_ONE   = LEN_WIDTH'(1);

    snr_evt_state_t state_q, state_d;

    logic accept;
    logic above_on, above_off;
    logic att_done, hold_done;

    logic att_clr, att_inc;
    logic hold_clr, hold_inc;
    logic len_clr, len_load, len_inc;
    logic peak_clr, peak_load, peak_upd;
    logic rec_load;

    logic [ATT_W-1:0]     att_cnt;
    logic [HOLD_W-1:0]    hold_cnt;
    logic [LEN_WIDTH-1:0] len_cnt;
    logic [LEN_WIDTH-1:0] len_load_val;
    logic [LEN_WIDTH-1:0] len_resume;
    logic [SUM_W-1:0]     len_sum;

    logic signed [SNR_WIDTH-1:0] peak_snr;
    logic        [DATA_WIDTH-1:0] peak_rms;

    assign accept    = in_valid & in_ready;
    assign above_on  = (snr_db >= ON_TH);
    assign above_off = (snr_db >= OFF_TH);
    // att_cnt is 0 in IDLE, so ATTACK_N==1 enters ACTIVE straight from IDLE.
    assign att_done  = (att_cnt == ATT_LAST);
    // hold_cnt is 0 in ACTIVE, so HOLD_N==1 reports on the first low sample.
    assign hold_done = (hold_cnt == HOLD_LAST);

    // Returning from RELEASE folds the bridged low samples plus the current
    // sample into the length, saturating at all-ones.
    assign len_sum      = SUM_W'(len_cnt) + SUM_W'(hold_cnt) + SUM_W'(1);
    assign len_resume   = (len_sum > SUM_W'(LEN_MAX)) ? LEN_MAX : len_sum[LEN_WIDTH-1:0];
    assign len_load_val = (state_q == RELEASE) ? len_resume : LEN_ONE;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_d   = state_q;
        att_clr   = 1'b0;
        att_inc   = 1'b0;
        hold_clr  = 1'b0;
        hold_inc  = 1'b0;
        len_clr   = 1'b0;
        len_load  = 1'b0;
        len_inc   = 1'b0;
        peak_clr  = 1'b0;
        peak_load = 1'b0;
        peak_upd  = 1'b0;
        rec_load  = 1'b0;
        unique case (state_q)
            IDLE, ATTACK: begin
                if (accept) begin
                    if (quiet_period) begin
                        state_d = IDLE;
                        att_clr = 1'b1;
                    end else if (above_on) begin
                        if (att_done) begin
                            state_d   = ACTIVE;
                            att_clr   = 1'b1;
                            hold_clr  = 1'b1;
                            len_load  = 1'b1;
                            peak_load = 1'b1;
                        end else begin
                            state_d = ATTACK;
                            att_inc = 1'b1;
                        end
                    end else begin
                        state_d = IDLE;
                        att_clr = 1'b1;
                    end
                end
            end
            ACTIVE, RELEASE: begin
                if (accept) begin
                    if (quiet_period) begin
                        state_d  = IDLE;
                        hold_clr = 1'b1;
                        len_clr  = 1'b1;
                        peak_clr = 1'b1;
                    end else if (above_off) begin
                        state_d  = ACTIVE;
                        peak_upd = 1'b1;
                        if (state_q == RELEASE) begin
                            hold_clr = 1'b1;
                            len_load = 1'b1;
                        end else begin
                            len_inc = 1'b1;
                        end
                    end else begin
                        hold_inc = 1'b1;
                        if (hold_done) begin
                            state_d  = REPORT;
                            rec_load = 1'b1;
                        end else begin
                            state_d = RELEASE;
                        end
                    end
                end
            end
            REPORT: begin
                if (ev_ready) begin
                    state_d  = IDLE;
                    att_clr  = 1'b1;
                    hold_clr = 1'b1;
                    len_clr  = 1'b1;
                    peak_clr = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded from the state register
    always_comb begin
        voice_active = (state_q == ACTIVE) || (state_q == RELEASE);
        ev_valid     = (state_q == REPORT);
        in_ready     = (state_q != REPORT);
        state_dbg    = state_q;
    end

    sat_counter #(.W(ATT_W)) u_att_cnt (
        .clk      (clk),
        .reset    (reset),
        .clr      (att_clr),
        .load     (1'b0),
        .load_val ('0),
        .inc      (att_inc),
        .count    (att_cnt)
    );

    sat_counter #(.W(HOLD_W)) u_hold_cnt (
        .clk      (clk),
        .reset    (reset),
        .clr      (hold_clr),
        .load     (1'b0),
        .load_val ('0),
        .inc      (hold_inc),
        .count    (hold_cnt)
    );

    sat_counter #(.W(LEN_WIDTH)) u_len_cnt (
        .clk      (clk),
        .reset    (reset),
        .clr      (len_clr),
        .load     (len_load),
        .load_val (len_load_val),
        .inc      (len_inc),
        .count    (len_cnt)
    );

    // Running peaks and the record registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            peak_snr    <= '0;
            peak_rms    <= '0;
            ev_peak_snr <= '0;
            ev_peak_rms <= '0;
            ev_len      <= '0;
        end else begin
            if (peak_clr) begin
                peak_snr <= '0;
                peak_rms <= '0;
            end else if (peak_load) begin
                peak_snr <= snr_db;
                peak_rms <= signal_rms;
            end else if (peak_upd) begin
                if (snr_db > peak_snr) begin
                    peak_snr <= snr_db;
                end
                if (signal_rms > peak_rms) begin
                    peak_rms <= signal_rms;
                end
            end
            // Low samples never touch the peaks or len, so the live values
            // are already the final record when the hold expires.
            if (rec_load) begin
                ev_peak_snr <= peak_snr;
                ev_peak_rms <= peak_rms;
                ev_len      <= len_cnt;
            end
        end
    end

endmodule

// File: tb/tb_snr_event_detector.sv
module tb_snr_event_detector;
    import mic_pkg::*;

    localparam int ON    = 12;
    localparam int OFF   = 6;
    localparam int ATT   = 4;
    localparam int HOLD  = 64;

    // clock / reset
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // main instance (default parameters)
    logic               quiet_period = 1'b0;
    logic signed [15:0] snr_db = '0;
    logic        [15:0] signal_rms = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic               voice_active;
    logic signed [15:0] ev_peak_snr;
    logic        [15:0] ev_peak_rms;
    logic        [15:0] ev_len;
    logic               ev_valid;
    logic               ev_ready = 1'b0;
    snr_evt_state_t     state_dbg;

    snr_event_detector dut (
        .clk(clk), .reset(reset), .quiet_period(quiet_period),
        .snr_db(snr_db), .signal_rms(signal_rms), .in_valid(in_valid),
        .in_ready(in_ready), .voice_active(voice_active),
        .ev_peak_snr(ev_peak_snr), .ev_peak_rms(ev_peak_rms), .ev_len(ev_len),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .state_dbg(state_dbg)
    );

    // small instance: narrow length, single-sample attack, short hold
    logic               s_quiet = 1'b0;
    logic signed [15:0] s_snr = '0;
    logic        [15:0] s_rms = '0;
    logic               s_valid = 1'b0;
    logic               s_in_ready;
    logic               s_voice;
    logic signed [15:0] s_peak_snr;
    logic        [15:0] s_peak_rms;
    logic        [3:0]  s_len;
    logic               s_ev_valid;
    logic               s_ev_ready = 1'b0;
    snr_evt_state_t     s_state_dbg;

    snr_event_detector #(.LEN_WIDTH(4), .ATTACK_N(1), .HOLD_N(4)) dut_s (
        .clk(clk), .reset(reset), .quiet_period(s_quiet),
        .snr_db(s_snr), .signal_rms(s_rms), .in_valid(s_valid),
        .in_ready(s_in_ready), .voice_active(s_voice),
        .ev_peak_snr(s_peak_snr), .ev_peak_rms(s_peak_rms), .ev_len(s_len),
        .ev_valid(s_ev_valid), .ev_ready(s_ev_ready), .state_dbg(s_state_dbg)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // driver tasks
    task automatic drive(input bit v, input bit q, input int s, input int r, input bit er);
        in_valid     = v;
        quiet_period = q;
        snr_db       = 16'(s);
        signal_rms   = 16'(r);
        ev_ready     = er;
        @(posedge clk);
        #1;
    endtask

    task automatic s_drive(input bit v, input int s, input int r, input bit er);
        s_valid    = v;
        s_snr      = 16'(s);
        s_rms      = 16'(r);
        s_ev_ready = er;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string name);
        in_valid = 1'b0; ev_ready = 1'b0; quiet_period = 1'b0;
        reset = 1'b1;
        #2;
        check({name, "_voice"}, voice_active, 0);
        check({name, "_ev_valid"}, ev_valid, 0);
        check({name, "_in_ready"}, in_ready, 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic check_rec(input string name, input int ps, input int pr, input int ln);
        check({name, "_ev_valid"}, ev_valid, 1);
        check({name, "_in_ready"}, in_ready, 0);
        check({name, "_peak_snr"}, longint'($signed(ev_peak_snr)), ps);
        check({name, "_peak_rms"}, ev_peak_rms, pr);
        check({name, "_len"}, ev_len, ln);
    endtask

    // reference model: keeps the samples of the open event in queues and
    // derives the record from them once the hold-off is satisfied
    bit         m_in_event;
    bit         m_pending;
    int         m_run;
    int         m_low;
    int         ev_snr_q[$];
    int         ev_rms_q[$];
    logic [47:0] exp_q[$];

    task automatic model_clear();
        m_in_event = 0; m_pending = 0; m_run = 0; m_low = 0;
        ev_snr_q.delete(); ev_rms_q.delete(); exp_q.delete();
    endtask

    task automatic model_sample(input bit q, input int sn, input int r);
        int n, ps, pr, ln;
        if (q) begin
            m_in_event = 0; m_run = 0; m_low = 0;
            ev_snr_q.delete(); ev_rms_q.delete();
            return;
        end
        if (!m_in_event) begin
            if (sn >= ON) begin
                m_run++;
                if (m_run == ATT) begin
                    m_in_event = 1; m_run = 0; m_low = 0;
                    ev_snr_q.push_back(sn); ev_rms_q.push_back(r);
                end
            end else begin
                m_run = 0;
            end
        end else begin
            ev_snr_q.push_back(sn); ev_rms_q.push_back(r);
            m_low = (sn >= OFF) ? 0 : m_low + 1;
            if (m_low == HOLD) begin
                n  = ev_snr_q.size() - HOLD;
                ln = (n > 65535) ? 65535 : n;
                ps = -32768; pr = 0;
                for (int i = 0; i < n; i++) begin
                    if (ev_snr_q[i] >= OFF) begin
                        if (ev_snr_q[i] > ps) ps = ev_snr_q[i];
                        if (ev_rms_q[i] > pr) pr = ev_rms_q[i];
                    end
                end
                exp_q.push_back({16'(ps), 16'(pr), 16'(ln)});
                m_pending = 1; m_in_event = 0; m_low = 0;
                ev_snr_q.delete(); ev_rms_q.delete();
            end
        end
    endtask

    typedef struct {
        bit v;
        int snr;
        bit exp_voice;
    } vec_t;

    vec_t tbl[13];

    initial begin
        bit          v, q, er, seen;
        int          sn, rv, mode;
        logic [47:0] rec;

        // reset values
        @(posedge clk);
        #1;
        check("rst_voice", voice_active, 0);
        check("rst_ev_valid", ev_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_peak_snr", ev_peak_snr, 0);
        check("rst_peak_rms", ev_peak_rms, 0);
        check("rst_len", ev_len, 0);
        check("rst_s_in_ready", s_in_ready, 1);
        reset = 1'b0;

        // debounce table: thresholds at exactly ON and OFF, idle cycles hold state
        tbl[0]  = '{1'b1, 12, 1'b0};
        tbl[1]  = '{1'b1, 12, 1'b0};
        tbl[2]  = '{1'b1, 12, 1'b0};
        tbl[3]  = '{1'b1, 5,  1'b0};
        tbl[4]  = '{1'b1, 12, 1'b0};
        tbl[5]  = '{1'b0, 5,  1'b0};
        tbl[6]  = '{1'b1, 12, 1'b0};
        tbl[7]  = '{1'b1, 12, 1'b0};
        tbl[8]  = '{1'b1, 12, 1'b1};
        tbl[9]  = '{1'b1, -3, 1'b1};
        tbl[10] = '{1'b0, -3, 1'b1};
        tbl[11] = '{1'b1, 6,  1'b1};
        tbl[12] = '{1'b1, 5,  1'b1};
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].v, 1'b0, tbl[i].snr, 10, 1'b0);
            check($sformatf("tbl%0d_voice", i), voice_active, tbl[i].exp_voice);
            check($sformatf("tbl%0d_ev_valid", i), ev_valid, 0);
        end

        // reset while an event is open
        do_reset("rst_mid");

        // full event; the length counts from the ACTIVE-entry sample
        for (int i = 0; i < 4; i++) drive(1, 0, 20, 100 * (i + 1), 0);
        check("full_voice_on", voice_active, 1);
        for (int i = 0; i < 10; i++) drive(1, 0, 15, 50, 0);
        for (int i = 0; i < 63; i++) drive(1, 0, 0, 1000, 0);
        check("full_before_last_ev_valid", ev_valid, 0);
        check("full_before_last_voice", voice_active, 1);
        drive(1, 0, 0, 1000, 0);
        check_rec("full", 20, 400, 11);
        check("full_voice_off", voice_active, 0);

        // backpressure: record stable, offered samples ignored
        for (int i = 0; i < 20; i++) begin
            drive(1, 0, 20, 7, 0);
            check_rec($sformatf("bp%0d", i), 20, 400, 11);
        end
        drive(0, 0, 0, 0, 1);
        check("bp_release_ev_valid", ev_valid, 0);
        check("bp_release_in_ready", in_ready, 1);
        for (int i = 0; i < 3; i++) drive(1, 0, 20, 7, 0);
        check("bp_fresh_attack_voice", voice_active, 0);
        drive(1, 0, 20, 7, 0);
        check("bp_fresh_active_voice", voice_active, 1);

        // hysteresis bounce: one record spanning the bridged low run
        do_reset("rst_bounce");
        for (int i = 0; i < 4; i++) drive(1, 0, 12, 10, 0);
        for (int i = 0; i < 30; i++) drive(1, 0, 0, 500, 0);
        check("bounce_voice_held", voice_active, 1);
        drive(1, 0, 8, 77, 0);
        for (int i = 0; i < 63; i++) drive(1, 0, 0, 500, 0);
        check("bounce_no_early_record", ev_valid, 0);
        drive(1, 0, 0, 500, 0);
        check_rec("bounce", 12, 77, 32);

        // reset while a record is pending drops it
        drive(0, 0, 0, 0, 0);
        do_reset("rst_report");

        // calibration abort mid-ACTIVE
        for (int i = 0; i < 9; i++) drive(1, 0, 12, 10, 0);
        drive(1, 1, 12, 10, 0);
        check("quiet_voice", voice_active, 0);
        seen = 0;
        for (int i = 0; i < 70; i++) begin
            drive(1, 0, 0, 10, 0);
            seen |= ev_valid;
        end
        check("quiet_no_record", seen, 0);

        // quiet_period has no effect on a pending record
        for (int i = 0; i < 4; i++) drive(1, 0, 12, 33, 0);
        for (int i = 0; i < 64; i++) drive(1, 0, 0, 10, 0);
        drive(1, 1, 0, 0, 0);
        check_rec("quiet_in_report", 12, 33, 1);
        drive(0, 0, 0, 0, 1);
        check("quiet_in_report_done", ev_valid, 0);

        // small instance: immediate attack, length saturation at 15
        s_drive(1, 12, 5, 0);
        check("s_attack1_voice", s_voice, 1);
        for (int i = 0; i < 19; i++) s_drive(1, (i == 9) ? 30 : 7, (i == 9) ? 900 : i, 0);
        for (int i = 0; i < 3; i++) s_drive(1, 0, 2000, 0);
        check("s_hold_ev_valid", s_ev_valid, 0);
        s_drive(1, 0, 2000, 0);
        check("s_ev_valid", s_ev_valid, 1);
        check("s_peak_snr", longint'($signed(s_peak_snr)), 30);
        check("s_peak_rms", s_peak_rms, 900);
        check("s_len_sat", s_len, 15);
        s_drive(0, 0, 0, 1);
        check("s_done", s_ev_valid, 0);

        // randomized run against the reference model
        do_reset("rst_rand");
        model_clear();
        mode = 0;
        for (int c = 0; c < 8000; c++) begin
            if ($urandom_range(0, 99) == 0) mode = $urandom_range(0, 3);
            v  = ($urandom_range(0, 4) != 0);
            q  = ($urandom_range(0, 399) == 0);
            er = ($urandom_range(0, 3) == 0);
            rv = int'($urandom_range(0, 65535));
            if (mode == 3 && $urandom_range(0, 9) != 0)
                sn = int'($urandom_range(12, 40));
            else if (mode == 2)
                sn = int'($urandom_range(6, 11));
            else
                sn = int'($urandom_range(0, 25)) - 20;
            if (m_pending && er) begin
                m_pending = 0;
                void'(exp_q.pop_front());
            end else if (v && !m_pending) begin
                model_sample(q, sn, rv);
            end
            drive(v, q, sn, rv, er);
            check("rand_voice", voice_active, m_in_event);
            check("rand_ev_valid", ev_valid, m_pending);
            check("rand_in_ready", in_ready, !m_pending);
            if (m_pending) begin
                rec = (exp_q.size() > 0) ? exp_q[0] : '0;
                check("rand_record", longint'({ev_peak_snr, ev_peak_rms, ev_len}), longint'(rec));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
